// File: rtl/vga_motion_ctrl.sv
// rtl/vga_motion_ctrl.sv - frame-synchronous bouncing-object motion controller
module vga_motion_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int OBJ_W      = 32,
    parameter int OBJ_H      = 32,
    parameter int X_INIT     = 304,
    parameter int Y_INIT     = 224,
    parameter int FRAME_LINE = V_ACTIVE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] h_counter,
    input  logic [11:0] v_counter,
    input  logic        run,
    input  logic        step,
    input  logic        recentre,
    input  logic [3:0]  speed_x,
    input  logic [3:0]  speed_y,
    output logic [11:0] obj_x,
    output logic [11:0] obj_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic [15:0] frame_count,
    output logic        busy,
    output logic        update_done
);

    localparam logic [11:0] X_MAX   = 12'(H_ACTIVE - OBJ_W);
    localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE - OBJ_H);
    localparam logic [11:0] X_START = 12'(X_INIT);
    localparam logic [11:0] Y_START = 12'(Y_INIT);
    localparam logic [11:0] EVT_LN  = 12'(FRAME_LINE);

    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [11:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        busy_q, busy_d, update_done_q, update_done_d;
    logic        step_pend_q, step_pend_d, rc_pend_q, rc_pend_d;
    logic        mv_q, mv_d, ld_q, ld_d;
    logic [3:0]  spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic [11:0] nx_q, nx_d, ny_q, ny_d;
    logic        ndx_q, ndx_d, ndy_q, ndy_d;
    logic        frame_evt;

    // Returns {new_dir, new_pos}; 13-bit sums keep the edge tests free of wrap.
    function automatic logic [12:0] axis_next(input logic [11:0] pos, input logic dir,
                                              input logic [3:0] spd, input logic [11:0] lim);
        logic [12:0] p13, s13, l13, sum;
        p13 = {1'b0, pos};
        s13 = {9'd0, spd};
        l13 = {1'b0, lim};
        sum = p13 + s13;
        axis_next = {dir, pos};
        if (spd != 4'd0) begin
            if (!dir) begin
                if (sum >= l13) axis_next = {1'b1, lim};
                else            axis_next = {1'b0, sum[11:0]};
            end else begin
                if (p13 <= s13) axis_next = {1'b0, 12'd0};
                else            axis_next = {1'b1, 12'(p13 - s13)};
            end
        end
    endfunction

    assign frame_evt = (h_counter == 12'd0) && (v_counter == EVT_LN);

    always_comb begin
        state_d       = state_q;
        obj_x_d       = obj_x_q;
        obj_y_d       = obj_y_q;
        dir_x_d       = dir_x_q;
        dir_y_d       = dir_y_q;
        frame_count_d = frame_count_q;
        mv_d          = mv_q;
        ld_d          = ld_q;
        spd_x_d       = spd_x_q;
        spd_y_d       = spd_y_q;
        nx_d          = nx_q;
        ny_d          = ny_q;
        ndx_d         = ndx_q;
        ndy_d         = ndy_q;
        update_done_d = 1'b0;
        // A pulse landing on the COMMIT cycle survives the clear and rolls into the next frame.
        step_pend_d   = step     | (step_pend_q & (state_q != COMMIT));
        rc_pend_d     = recentre | (rc_pend_q   & (state_q != COMMIT));

        case (state_q)
            IDLE: begin
                if (frame_evt) begin
                    state_d = CALC_X;
                    mv_d    = run | step_pend_q | step;
                    ld_d    = rc_pend_q | recentre;
                    spd_x_d = speed_x;
                    spd_y_d = speed_y;
                end
            end
            CALC_X: begin
                {ndx_d, nx_d} = axis_next(obj_x_q, dir_x_q, spd_x_q, X_MAX);
                state_d       = CALC_Y;
            end
            CALC_Y: begin
                {ndy_d, ny_d} = axis_next(obj_y_q, dir_y_q, spd_y_q, Y_MAX);
                state_d       = COMMIT;
            end
            COMMIT: begin
                if (ld_q) begin
                    obj_x_d = X_START;
                    obj_y_d = Y_START;
                    dir_x_d = 1'b0;
                    dir_y_d = 1'b0;
                end else if (mv_q) begin
                    obj_x_d = nx_q;
                    obj_y_d = ny_q;
                    dir_x_d = ndx_q;
                    dir_y_d = ndy_q;
                end
                frame_count_d = frame_count_q + 16'd1;
                update_done_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            obj_x_q       <= X_START;
            obj_y_q       <= Y_START;
            dir_x_q       <= 1'b0;
            dir_y_q       <= 1'b0;
            frame_count_q <= 16'd0;
            busy_q        <= 1'b0;
            update_done_q <= 1'b0;
            step_pend_q   <= 1'b0;
            rc_pend_q     <= 1'b0;
            mv_q          <= 1'b0;
            ld_q          <= 1'b0;
            spd_x_q       <= 4'd0;
            spd_y_q       <= 4'd0;
            nx_q          <= 12'd0;
            ny_q          <= 12'd0;
            ndx_q         <= 1'b0;
            ndy_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            obj_x_q       <= obj_x_d;
            obj_y_q       <= obj_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            update_done_q <= update_done_d;
            step_pend_q   <= step_pend_d;
            rc_pend_q     <= rc_pend_d;
            mv_q          <= mv_d;
            ld_q          <= ld_d;
            spd_x_q       <= spd_x_d;
            spd_y_q       <= spd_y_d;
            nx_q          <= nx_d;
            ny_q          <= ny_d;
            ndx_q         <= ndx_d;
            ndy_q         <= ndy_d;
        end
    end

    assign obj_x       = obj_x_q;
    assign obj_y       = obj_y_q;
    assign dir_x       = dir_x_q;
    assign dir_y       = dir_y_q;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_vga_motion_ctrl.sv
// tb/tb_vga_motion_ctrl.sv - directed scoreboard bench for vga_motion_ctrl
module tb_vga_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] h_counter = 12'd7;
    logic [11:0] v_counter = 12'd100;
    logic        run = 1'b0, step = 1'b0, recentre = 1'b0;
    logic [3:0]  speed_x = 4'd0, speed_y = 4'd0;
    logic [11:0] obj_x, obj_y;
    logic        dir_x, dir_y, busy, update_done;
    logic [15:0] frame_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int x;
        int y;
        bit dx;
        bit dy;
        int fc;
    } exp_t;
    exp_t sb[$];

    // Reference state of the object and the request latches.
    int mx = 304, my = 224, mfc = 0;
    bit mdx = 0, mdy = 0, mstep = 0, mrc = 0;

    always #5 clk = ~clk;

    vga_motion_ctrl dut (
        .clk(clk), .rst(rst), .h_counter(h_counter), .v_counter(v_counter),
        .run(run), .step(step), .recentre(recentre),
        .speed_x(speed_x), .speed_y(speed_y),
        .obj_x(obj_x), .obj_y(obj_y), .dir_x(dir_x), .dir_y(dir_y),
        .frame_count(frame_count), .busy(busy), .update_done(update_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_axis(inout int p, inout bit d, input int s, input int lim);
        if (s == 0) return;
        if (!d) begin
            if (p + s >= lim) begin p = lim; d = 1; end
            else p = p + s;
        end else begin
            if (p <= s) begin p = 0; d = 0; end
            else p = p - s;
        end
    endtask

    task automatic model_frame();
        exp_t e;
        if (mrc) begin
            mx = 304; my = 224; mdx = 0; mdy = 0;
        end else if (run || mstep) begin
            model_axis(mx, mdx, int'(speed_x), 608);
            model_axis(my, mdy, int'(speed_y), 448);
        end
        mfc = (mfc + 1) % 65536;
        mstep = 0;
        mrc = 0;
        e.x = mx; e.y = my; e.dx = mdx; e.dy = mdy; e.fc = mfc;
        sb.push_back(e);
    endtask

    task automatic frame(input bit rc_at_commit);
        exp_t e;
        int cyc;
        model_frame();
        @(negedge clk);
        h_counter = 12'd0;
        v_counter = 12'd480;
        @(posedge clk); #1;
        h_counter = 12'd7;
        v_counter = 12'd100;
        cyc = 1;
        chk("busy_after_event", busy, 1);
        while (!update_done && cyc < 12) begin
            if (rc_at_commit && cyc == 3) recentre = 1'b1;
            @(posedge clk); #1;
            recentre = 1'b0;
            cyc++;
        end
        chk("update_latency", cyc, 4);
        chk("busy_at_done", busy, 0);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("obj_x", obj_x, e.x);
            chk("obj_y", obj_y, e.y);
            chk("dir_x", dir_x, e.dx);
            chk("dir_y", dir_y, e.dy);
            chk("frame_count", frame_count, e.fc);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", update_done, 0);
        if (rc_at_commit) mrc = 1;
    endtask

    task automatic pulse_step();
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        mstep = 1;
    endtask

    task automatic pulse_recentre();
        @(negedge clk); recentre = 1'b1;
        @(negedge clk); recentre = 1'b0;
        mrc = 1;
    endtask

    initial begin
        int ud_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obj_x", obj_x, 304);
        chk("rst_obj_y", obj_y, 224);
        chk("rst_dir_x", dir_x, 0);
        chk("rst_dir_y", dir_y, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_update_done", update_done, 0);
        @(negedge clk); rst = 1'b0;

        // Idle frames with run low.
        repeat (3) frame(0);
        chk("idle_fc3", frame_count, 3);
        chk("idle_x", obj_x, 304);

        // Walk right to x=600, then bounce off the right edge.
        run = 1'b1; speed_x = 4'd8; speed_y = 4'd0;
        repeat (37) frame(0);
        chk("reach_600", obj_x, 600);
        speed_x = 4'd5;
        frame(0); chk("right_605", obj_x, 605);
        frame(0); chk("right_608", obj_x, 608); chk("right_dir", dir_x, 1);
        frame(0); chk("right_603", obj_x, 603); chk("right_y_hold", obj_y, 224);

        // Left edge: walk down to x=3 then bounce at speed 4.
        repeat (120) frame(0);
        chk("reach_3", obj_x, 3); chk("reach_3_dir", dir_x, 1);
        speed_x = 4'd4;
        frame(0); chk("left_0", obj_x, 0); chk("left_dir", dir_x, 0);
        frame(0); chk("left_4", obj_x, 4);

        // Bottom bounce, then top bounce from y=2 at speed 2.
        speed_x = 4'd0; speed_y = 4'd8;
        repeat (28) frame(0);
        chk("bottom_448", obj_y, 448); chk("bottom_dir", dir_y, 1);
        speed_y = 4'd2;
        repeat (223) frame(0);
        chk("reach_y2", obj_y, 2);
        frame(0); chk("top_0", obj_y, 0); chk("top_dir", dir_y, 0);
        chk("top_x_hold", obj_x, 4);

        // Pause and double step: exactly one move.
        pulse_recentre();
        frame(0); chk("recentre_x", obj_x, 304);
        run = 1'b0; speed_x = 4'd2; speed_y = 4'd0;
        pulse_step(); pulse_step();
        frame(0); chk("step_306", obj_x, 306);
        frame(0); chk("step_hold", obj_x, 306);

        // Recentre beats step; both latches clear.
        pulse_step(); pulse_recentre();
        frame(0); chk("prio_x", obj_x, 304); chk("prio_y", obj_y, 224);
        frame(0); chk("prio_cleared", obj_x, 304);

        // Recentre in the COMMIT cycle defers to the next frame.
        run = 1'b1;
        frame(1); chk("late_rc_move", obj_x, 306);
        frame(0); chk("late_rc_applied", obj_x, 304);
        frame(0); chk("late_rc_gone", obj_x, 306);

        // Async reset while in CALC_Y.
        @(negedge clk);
        h_counter = 12'd0; v_counter = 12'd480;
        @(posedge clk); #1;
        h_counter = 12'd7; v_counter = 12'd100;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_obj_x", obj_x, 304);
        chk("arst_frame_count", frame_count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", update_done, 0);
        @(negedge clk); rst = 1'b0;
        mx = 304; my = 224; mdx = 0; mdy = 0; mfc = 0; mstep = 0; mrc = 0;
        ud_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (update_done) ud_seen++;
        end
        chk("arst_no_done", ud_seen, 0);
        frame(0); chk("post_rst_fc", frame_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
